// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   INSTR_W          instruction word width
//   OPC_MSB/OPC_LSB  opcode field inside an instruction word
//   DEFAULT_RESET_PC default PC loaded on reset
//   fetch_entry_t    prefetch buffer entry {instr, pc}; pc is stored at
//                    PC_MAX_W and narrowed by the user to its own PC width.
package fetch_pkg;
  localparam int INSTR_W          = 32;
  localparam int OPC_MSB          = 31;
  localparam int OPC_LSB          = 27;
  localparam int DEFAULT_RESET_PC = 0;
  localparam int PC_MAX_W         = 32;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with registered storage.
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries at the next edge (wins over push/pop)
//   push_i, din_i  write an entry
//   pop_i          remove the head entry
//   dout_o         head entry (meaningful only when !empty_o)
//   count_o        number of valid entries; empty_o / full_o status
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q] <= din_i;

  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk_i)
    if (!rst_i && !flush_i) begin
      assert (!(push_i && full_o && !pop_i));
      assert (!(pop_i && empty_o));
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   clock, reset                     clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data    in-order, variable-latency responses
//   redirect_valid, redirect_pc      jump/branch: flush and refetch
//   instr_valid/ready, instr,        instruction handed to decode with its
//   instr_pc, instr_pc_plus1         address and address+1
//   perf_fetched, perf_stall         present only with FETCH_PERF_CNT_EN
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 12,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] instr_pc_plus1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall
`endif
);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       outst_q, outst_d;   // all requests awaiting a response
  logic [CW-1:0]       drop_q, drop_d;     // responses still owed to stale requests
  logic                post_rst_q;
  logic                req_fire, rsp_keep, deq;
  logic [CW-1:0]       buf_cnt, pcq_cnt;
  logic                buf_empty, buf_full, pcq_empty, pcq_full;
  logic [PC_WIDTH-1:0] pcq_head;
  fetch_entry_t        buf_din, buf_head;

  // Credit = buffered + outstanding; a response always has a slot waiting.
  // A same-cycle dequeue does not free credit, so with DEPTH=2 the
  // sustained rate is two instructions every three cycles. post_rst_q
  // keeps the request side quiet for the cycle right after reset.
  assign imem_req_valid = !reset && !post_rst_q && !redirect_valid &&
                          (({1'b0, buf_cnt} + {1'b0, outst_q}) < DEPTH_C);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response in the redirect cycle belongs to pre-redirect fetch: discard.
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  assign instr_valid    = !reset && !buf_empty && !redirect_valid;
  assign deq            = instr_valid && instr_ready;
  assign instr          = instr_valid ? buf_head.instr : '0;
  assign instr_pc       = instr_valid ? buf_head.pc[PC_WIDTH-1:0] : '0;
  assign instr_pc_plus1 = instr_pc + 1'b1;

  assign buf_din.instr  = imem_rsp_data;
  assign buf_din.pc     = PC_MAX_W'(pcq_head);

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      // Everything still outstanding is stale, minus the one retiring now.
      drop_d = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 1'b1;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    post_rst_q <= reset;
    if (reset) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // PCs of live requests, popped in step with the responses they match.
  fetch_fifo #(.DEPTH(DEPTH), .W(PC_WIDTH)) u_pcq (
    .clk_i(clock), .rst_i(reset), .flush_i(redirect_valid),
    .push_i(req_fire), .pop_i(rsp_keep), .din_i(pc_q),
    .dout_o(pcq_head), .count_o(pcq_cnt), .empty_o(pcq_empty), .full_o(pcq_full)
  );

  // Prefetch buffer toward decode.
  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_buf (
    .clk_i(clock), .rst_i(reset), .flush_i(redirect_valid),
    .push_i(rsp_keep), .pop_i(deq), .din_i(buf_din),
    .dout_o(buf_head), .count_o(buf_cnt), .empty_o(buf_empty), .full_o(buf_full)
  );

  logic unused_sig;
  assign unused_sig = ^{pcq_cnt, pcq_full, buf_head.pc[PC_MAX_W-1:PC_WIDTH]};

  // A kept response must have a matching request PC and a free buffer slot.
  always_ff @(posedge clock)
    if (!reset) begin
      assert (!(rsp_keep && pcq_empty));
      assert (!(rsp_keep && buf_full && !deq));
    end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (deq)          perf_fetched_q <= perf_fetched_q + 1'b1;
      if (!instr_valid) perf_stall_q   <= perf_stall_q + 1'b1;
    end
  end
  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int PCW = 12;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           imem_req_valid, imem_req_ready = 1'b1;
  logic [PCW-1:0] imem_addr;
  logic           imem_rsp_valid = 1'b0;
  logic [31:0]    imem_rsp_data = '0;
  logic           redirect_valid = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic           instr_valid, instr_ready = 1'b1;
  logic [31:0]    instr;
  logic [PCW-1:0] instr_pc, instr_pc_plus1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]    perf_fetched, perf_stall;
`endif

  always #5 clock = ~clock;

  fetch_unit #(.PC_WIDTH(PCW), .DEPTH(2), .RESET_PC(12'h000)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus1(instr_pc_plus1)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, lat = 1, fires = 0, hs = 0, stall_cnt = 0;
  int first_v = -1, rel_cyc = -1;
  logic [PCW-1:0] mpc = '0, rd_target = '0;
  logic after_rd = 1'b0;

  typedef struct { logic [PCW-1:0] a; int due; } mreq_t;
  typedef struct { logic [31:0] d; logic [PCW-1:0] pc; } exp_t;
  mreq_t mq[$];   // memory model: accepted requests awaiting response
  exp_t  sb[$];   // scoreboard: instructions decode should still receive

  function automatic logic [31:0] mdata(input logic [PCW-1:0] a);
    return {a[4:0], 15'h55A5, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock cycle: observe at negedge, then advance and drive memory.
  task automatic step();
    exp_t e;
    logic [PCW-1:0] p1;
    @(negedge clock);
    if (reset) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instr", instr, 0);
      check("rst_instr_pc", instr_pc, 0);
      mq.delete(); sb.delete(); mpc = 12'h000;
    end else begin
      if (cyc == rel_cyc) begin
        check("post_rst_req_valid", imem_req_valid, 0);
        check("post_rst_instr_valid", instr_valid, 0);
        check("post_rst_instr", instr, 0);
        check("post_rst_instr_pc", instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
        check("post_rst_perf_fetched", perf_fetched, 0);
        check("post_rst_perf_stall", perf_stall, 0);
`endif
      end
      if (instr_valid && first_v < 0) first_v = cyc;
      if (!instr_valid) stall_cnt++;
      if (instr_valid && instr_ready) begin
        hs++;
        if (sb.size() == 0) check("unexpected_instr_valid", instr_valid, 0);
        else begin
          e = sb.pop_front();
          p1 = e.pc + 12'd1;
          check("instr", instr, e.d);
          check("instr_pc", instr_pc, e.pc);
          check("instr_pc_plus1", instr_pc_plus1, p1);
          if (after_rd) begin
            check("first_pc_after_restart", instr_pc, rd_target);
            after_rd = 1'b0;
          end
        end
      end
      if (redirect_valid) check("req_during_redirect", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_addr, mpc);
        mq.push_back('{a: imem_addr, due: cyc + lat});
        sb.push_back('{d: mdata(mpc), pc: mpc});
        mpc++;
        fires++;
      end
      if (redirect_valid) begin
        sb.delete();
        mpc = redirect_pc;
        after_rd = 1'b1;
        rd_target = redirect_pc;
      end
    end
    @(posedge clock); #1;
    cyc++;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    rel_cyc = cyc; first_v = -1; hs = 0; fires = 0; stall_cnt = 0;
    after_rd = 1'b1; rd_target = 12'h000;
    step();
  endtask

  task automatic redirect(input logic [PCW-1:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_fires(input int n, input string tag);
    for (int i = 0; i < 10 && fires < n; i++) step();
    check(tag, fires, n);
  endtask

  initial begin
    int hs0;
    // 1: single-cycle memory, decode always ready
    lat = 1; instr_ready = 1'b1;
    do_reset(2);
    repeat (2) step();
    hs0 = hs;
    repeat (12) step();
    check("first_valid_latency", first_v - rel_cyc, 3);
    check("steady_throughput", hs - hs0, 8);

    // 2: decode stalled: credit limit, stable head, then drain in order
    instr_ready = 1'b0;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i >= 4) check("hold_instr_pc", instr_pc, 0);
    end
    check("hold_fires", fires, 2);
    check("hold_req_valid", imem_req_valid, 0);
    check("hold_instr_valid", instr_valid, 1);
    check("hold_instr", instr, mdata(12'h000));
    instr_ready = 1'b1;
    repeat (12) step();
    check("drain_count", hs, 2 + (fires - 2) - sb.size());

    // 3: latency 3, redirect with two requests outstanding
    lat = 3;
    do_reset(1);
    wait_fires(2, "rd_setup_fires");
    redirect(12'h100);
    repeat (15) step();
    check("rd_target_delivered", after_rd, 0);

    // 4: redirect in the same cycle as a response
    do_reset(1);
    wait_fires(2, "rsp_rd_setup_fires");
    step();
    check("rsp_rd_rsp_present", imem_rsp_valid, 1);
    redirect(12'h2A0);
    repeat (15) step();
    check("rsp_rd_target_delivered", after_rd, 0);

    // 5: PC wrap at the top of the address space
    lat = 1;
    redirect(12'hFFE);
    repeat (15) step();
    check("wrap_target_delivered", after_rd, 0);
    check("wrap_mpc_past_zero", (mpc < 12'h100), 1);

    // 6: reset mid-stream with two requests outstanding
    lat = 3;
    do_reset(1);
    wait_fires(2, "midrst_setup_fires");
    do_reset(1);
    repeat (20) step();
    check("midrst_restart_delivered", after_rd, 0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, hs);
    check("perf_stall", perf_stall, stall_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end
endmodule
